// File: rtl/sink_pkg.sv
// Shared types and constants for the stream sink: state encoding and error-counter sizing.
package sink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ERR_W = 16;
  localparam logic [ERR_W-1:0] ERR_SAT = 16'hFFFF;

endpackage

// File: rtl/sink_if.sv
// Valid/ready stream bundle between an upstream source (master) and the sink (slave).
interface sink_if #(
  parameter int WIDTH = 8
) ();

  logic             vaild;
  logic [WIDTH-1:0] data_in;
  logic             ready;

  modport master (output vaild, output data_in, input ready);
  modport slave  (input vaild, input data_in, output ready);

endinterface

// File: rtl/sink_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module sync_edge (
  input  logic clk,
  input  logic s_rst,
  input  logic async_in,
  output logic rise
);

  logic sync_r1;
  logic sync_r2;
  logic sync_r3;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      sync_r1 <= 1'b0;
      sync_r2 <= 1'b0;
      sync_r3 <= 1'b0;
    end else begin
      sync_r1 <= async_in;
      sync_r2 <= sync_r1;
      sync_r3 <= sync_r2;
    end
  end

  assign rise = sync_r2 & ~sync_r3;

endmodule

// File: rtl/sink.sv
// Stream sink: accepts DEPTH words under a rotating ready pattern, stores them, and
// checks each against the incrementing sequence 1, 2, 3, ... (truncated to WIDTH).
//
// state | meaning
// IDLE  | after reset, waiting for the first start edge
// RECV  | accepting words; ready follows the rotating pattern
// DONE  | DEPTH words accepted; results held until a restart
module sink
  import sink_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 256,
  parameter int              PAT_W     = 8,
  parameter logic [PAT_W-1:0] READY_PAT = 8'b1111_1111,
  localparam int             AW        = $clog2(DEPTH),
  localparam int             CW        = AW + 1
) (
  input  logic              clk,
  input  logic              s_rst,
  input  logic              start,
  sink_if.slave             stream,
  output logic              done,
  output logic [CW-1:0]     rx_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [CW-1:0]     first_err_idx,
  input  logic [AW-1:0]     rb_addr,
  output logic [WIDTH-1:0]  rb_data
);

  state_t           state;
  state_t           state_nxt;
  logic             start_rise;
  logic             run_load;
  logic             hs;
  logic             last_word;
  logic             mismatch;
  logic [WIDTH-1:0] expected;
  logic [PAT_W-1:0] pat;
  logic [WIDTH-1:0] mem [DEPTH];

  sync_edge u_sync_edge (
    .clk      (clk),
    .s_rst    (s_rst),
    .async_in (start),
    .rise     (start_rise)
  );

  assign stream.ready = (state == RECV) & pat[0];
  assign hs           = stream.vaild & stream.ready;
  assign last_word    = (rx_cnt == CW'(DEPTH - 1));
  // Word n (0-based) should carry n+1; the cast deliberately wraps to WIDTH bits.
  assign expected     = WIDTH'(rx_cnt + CW'(1));
  assign mismatch     = (stream.data_in != expected);
  assign done         = (state == DONE);

  always_ff @(posedge clk) begin
    if (s_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run_load  = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_nxt = RECV;
          run_load  = 1'b1;
        end
      end
      RECV: begin
        if (hs && last_word) state_nxt = DONE;
      end
      DONE: begin
        if (start_rise) begin
          state_nxt = RECV;
          run_load  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      rx_cnt        <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      pat           <= READY_PAT;
    end else if (run_load) begin
      rx_cnt        <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      pat           <= READY_PAT;
    end else if (state == RECV) begin
      pat <= {pat[0], pat[PAT_W-1:1]};
      if (hs) begin
        rx_cnt <= rx_cnt + CW'(1);
        if (mismatch) begin
          if (err_cnt != ERR_SAT) err_cnt <= err_cnt + ERR_W'(1);
          if (err_cnt == '0)      first_err_idx <= rx_cnt;
        end
      end
    end
  end

  // Buffer is never cleared; an aborted run leaves its partial data behind.
  always_ff @(posedge clk) begin
    if (hs && !s_rst) mem[rx_cnt[AW-1:0]] <= stream.data_in;
  end

  always_ff @(posedge clk) begin
    if (s_rst) rb_data <= '0;
    else       rb_data <= mem[rb_addr];
  end

endmodule
